// File: rtl/alu_seq_ctrl_if.sv
// Request/response bundle between the main control unit and alu_seq_ctrl.
// The master issues operations and the slave (the ALU) returns registered results.
interface alu_seq_ctrl_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [3:0]       sel;
    logic             err;

    modport master (
        output start, alu_op, funct, a, b,
        input  busy, done, result, zero, sel, err
    );

    modport slave (
        input  start, alu_op, funct, a, b,
        output busy, done, result, zero, sel, err
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Registered MIPS ALU control and execution unit; iterative MUL/DIV are compiled in
// only when ALU_MULDIV_EN is defined, otherwise those functs decode as illegal.
module alu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_ctrl_if.slave bus
);

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_SLL = 4'b1000;
    localparam logic [3:0] SEL_SRL = 4'b1001;
    localparam logic [3:0] SEL_NOR = 4'b1100;
    localparam logic [3:0] SEL_XOR = 4'b1101;
    localparam logic [3:0] SEL_ILL = 4'b1111;
`ifdef ALU_MULDIV_EN
    localparam logic [3:0]     SEL_MUL  = 4'b0011;
    localparam logic [3:0]     SEL_DIV  = 4'b0100;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
`else
    typedef enum logic [0:0] {S_IDLE, S_DONE} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;          // staged result, or product/remainder
    logic [3:0]       pend_sel_q, pend_sel_d;
    logic             pend_err_q, pend_err_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [3:0]       sel_q, sel_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
`ifdef ALU_MULDIV_EN
    logic [WIDTH-1:0] op_x_q, op_x_d;        // multiplicand / divisor
    logic [WIDTH-1:0] op_y_q, op_y_d;        // multiplier / dividend shifting into quotient
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]   div_rem_sh;
    logic             div_ge;
`endif

    logic [3:0]       dec_sel;
    logic [WIDTH-1:0] alu_res;

    always_comb begin
        dec_sel = SEL_ILL;
        case (bus.alu_op)
            2'b00: dec_sel = SEL_ADD;
            2'b01: dec_sel = SEL_SUB;
            2'b10: begin
                case (bus.funct)
                    6'b100000: dec_sel = SEL_ADD;
                    6'b100010: dec_sel = SEL_SUB;
                    6'b100100: dec_sel = SEL_AND;
                    6'b100101: dec_sel = SEL_OR;
                    6'b100111: dec_sel = SEL_NOR;
                    6'b100110: dec_sel = SEL_XOR;
                    6'b101010: dec_sel = SEL_SLT;
                    6'b000000: dec_sel = SEL_SLL;
                    6'b000011: dec_sel = SEL_SRL;
`ifdef ALU_MULDIV_EN
                    6'b000010: dec_sel = SEL_MUL;
                    6'b011010: dec_sel = SEL_DIV;
`endif
                    default:   dec_sel = SEL_ILL;
                endcase
            end
            default: dec_sel = SEL_ILL;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (dec_sel)
            SEL_ADD: alu_res = bus.a + bus.b;
            SEL_SUB: alu_res = bus.a - bus.b;
            SEL_AND: alu_res = bus.a & bus.b;
            SEL_OR:  alu_res = bus.a | bus.b;
            SEL_NOR: alu_res = ~(bus.a | bus.b);
            SEL_XOR: alu_res = bus.a ^ bus.b;
            SEL_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            SEL_SLL: alu_res = bus.a << bus.b[SHW-1:0];
            SEL_SRL: alu_res = bus.a >> bus.b[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        acc_d      = acc_q;
        pend_sel_d = pend_sel_q;
        pend_err_d = pend_err_q;
        result_d   = result_q;
        zero_d     = zero_q;
        sel_d      = sel_q;
        err_d      = err_q;
        done_d     = 1'b0;
`ifdef ALU_MULDIV_EN
        op_x_d     = op_x_q;
        op_y_d     = op_y_q;
        cnt_d      = cnt_q;
        div_rem_sh = {acc_q, op_y_q[WIDTH-1]};
        div_ge     = div_rem_sh >= {1'b0, op_x_q};
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pend_sel_d = dec_sel;
                    pend_err_d = (dec_sel == SEL_ILL);
                    acc_d      = alu_res;
                    state_d    = S_DONE;
`ifdef ALU_MULDIV_EN
                    if (dec_sel == SEL_MUL) begin
                        acc_d   = '0;
                        op_x_d  = bus.a;
                        op_y_d  = bus.b;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else if (dec_sel == SEL_DIV) begin
                        if (bus.b == '0) begin
                            acc_d      = '1;
                            pend_err_d = 1'b1;
                        end else begin
                            acc_d   = '0;
                            op_x_d  = bus.b;
                            op_y_d  = bus.a;
                            cnt_d   = '0;
                            state_d = S_DIV;
                        end
                    end
`endif
                end
            end
`ifdef ALU_MULDIV_EN
            S_MUL: begin
                if (op_y_q[0]) acc_d = acc_q + op_x_q;
                op_x_d = op_x_q << 1;
                op_y_d = op_y_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
            S_DIV: begin
                // Restoring step: remainder is trial-subtracted, quotient bit shifts in at LSB.
                acc_d  = div_ge ? WIDTH'(div_rem_sh - {1'b0, op_x_q}) : WIDTH'(div_rem_sh);
                op_y_d = {op_y_q[WIDTH-2:0], div_ge};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    acc_d   = op_y_d;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                result_d = acc_q;
                zero_d   = (acc_q == '0);
                sel_d    = pend_sel_q;
                err_d    = pend_err_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            pend_sel_q <= '0;
            pend_err_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            sel_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef ALU_MULDIV_EN
            op_x_q     <= '0;
            op_y_q     <= '0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            pend_sel_q <= pend_sel_d;
            pend_err_q <= pend_err_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            sel_q      <= sel_d;
            err_q      <= err_d;
            done_q     <= done_d;
`ifdef ALU_MULDIV_EN
            op_x_q     <= op_x_d;
            op_y_q     <= op_y_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.sel    = sel_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: the driver queues hand-computed results, a monitor
// pops and compares on every done pulse. Expectations follow ALU_MULDIV_EN.
module tb_alu_seq_ctrl;

    localparam int W = 32;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000011;
    localparam logic [5:0] F_MUL = 6'b000010;
    localparam logic [5:0] F_DIV = 6'b011010;
    localparam logic [5:0] F_BAD = 6'b111111;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  sel;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.WIDTH(W)) bus ();

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Issue one op, queue its expected response, and measure latency and busy cycles.
    task automatic issue(input string name, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] er, input logic [3:0] es, input logic ee,
                         input int lat, input bit poke);
        exp_t e;
        int   n;
        int   busy_n;
        e.name = name; e.res = er; e.sel = es; e.err = ee;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = op; bus.funct = fn; bus.a = av; bus.b = bv;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_n = bus.busy ? 1 : 0;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            if (poke && i == 5) begin
                bus.start = 1'b1; bus.alu_op = 2'b10; bus.funct = F_ADD;
                bus.a = 32'd1; bus.b = 32'd1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin
                n = i;
                break;
            end
            if (bus.busy) busy_n++;
        end
        check({name, "_latency"}, n, lat);
        check({name, "_busy_cycles"}, busy_n, lat);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                check("sb_nonempty_on_done", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, bus.result, e.res);
                    check({e.name, "_sel"}, bus.sel, e.sel);
                    check({e.name, "_err"}, bus.err, e.err);
                    check({e.name, "_zero"}, bus.zero, e.res == 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int dn;
        bus.start = 1'b0; bus.alu_op = 2'b00; bus.funct = 6'b0; bus.a = '0; bus.b = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_zero", bus.zero, 1);
        check("rst_sel", bus.sel, 4'b0000);
        check("rst_err", bus.err, 0);

        issue("add_5_7", 2'b10, F_ADD, 32'd5, 32'd7, 32'd12, 4'b0010, 1'b0, 1, 1'b0);

        issue("sw_add", 2'b10, F_ADD, 32'hF0F0F0F0, 32'h4, 32'hF0F0F0F4, 4'b0010, 1'b0, 1, 1'b0);
        issue("sw_sub", 2'b10, F_SUB, 32'hF0F0F0F0, 32'h4, 32'hF0F0F0EC, 4'b0110, 1'b0, 1, 1'b0);
        issue("sw_and", 2'b10, F_AND, 32'hF0F0F0F0, 32'h4, 32'h00000000, 4'b0000, 1'b0, 1, 1'b0);
        issue("sw_or",  2'b10, F_OR,  32'hF0F0F0F0, 32'h4, 32'hF0F0F0F4, 4'b0001, 1'b0, 1, 1'b0);
        issue("sw_nor", 2'b10, F_NOR, 32'hF0F0F0F0, 32'h4, 32'h0F0F0F0B, 4'b1100, 1'b0, 1, 1'b0);
        issue("sw_xor", 2'b10, F_XOR, 32'hF0F0F0F0, 32'h4, 32'hF0F0F0F4, 4'b1101, 1'b0, 1, 1'b0);
        issue("sw_slt", 2'b10, F_SLT, 32'hF0F0F0F0, 32'h4, 32'h00000001, 4'b0111, 1'b0, 1, 1'b0);
        issue("sw_sll", 2'b10, F_SLL, 32'hF0F0F0F0, 32'h4, 32'h0F0F0F00, 4'b1000, 1'b0, 1, 1'b0);
        issue("sw_srl", 2'b10, F_SRL, 32'hF0F0F0F0, 32'h4, 32'h0F0F0F0F, 4'b1001, 1'b0, 1, 1'b0);

        issue("slt_pos_false", 2'b10, F_SLT, 32'd5, 32'd3, 32'd0, 4'b0111, 1'b0, 1, 1'b0);
        issue("slt_pos_true",  2'b10, F_SLT, 32'd3, 32'd5, 32'd1, 4'b0111, 1'b0, 1, 1'b0);
        issue("srl_31", 2'b10, F_SRL, 32'h80000000, 32'h1F, 32'd1, 4'b1001, 1'b0, 1, 1'b0);
        issue("sll_mask", 2'b10, F_SLL, 32'h1, 32'h21, 32'h2, 4'b1000, 1'b0, 1, 1'b0);
        issue("op00_add", 2'b00, F_BAD, 32'd3, 32'd4, 32'd7, 4'b0010, 1'b0, 1, 1'b0);
        issue("op01_eq", 2'b01, F_BAD, 32'd9, 32'd9, 32'd0, 4'b0110, 1'b0, 1, 1'b0);
        issue("op01_wrap", 2'b01, F_ADD, 32'd0, 32'd1, 32'hFFFFFFFF, 4'b0110, 1'b0, 1, 1'b0);
        issue("add_wrap", 2'b10, F_ADD, 32'hFFFFFFFF, 32'd2, 32'd1, 4'b0010, 1'b0, 1, 1'b0);
        issue("op11_ill", 2'b11, F_ADD, 32'd9, 32'd9, 32'd0, 4'b1111, 1'b1, 1, 1'b0);
        issue("funct_ill", 2'b10, F_BAD, 32'd9, 32'd9, 32'd0, 4'b1111, 1'b1, 1, 1'b0);

`ifdef ALU_MULDIV_EN
        issue("sw_mul", 2'b10, F_MUL, 32'hF0F0F0F0, 32'h4, 32'hC3C3C3C0, 4'b0011, 1'b0, 33, 1'b0);
        issue("sw_div", 2'b10, F_DIV, 32'hF0F0F0F0, 32'h4, 32'h3C3C3C3C, 4'b0100, 1'b0, 33, 1'b0);
        issue("mul_ffff", 2'b10, F_MUL, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 4'b0011, 1'b0, 33, 1'b1);
        issue("div_100_7", 2'b10, F_DIV, 32'd100, 32'd7, 32'd14, 4'b0100, 1'b0, 33, 1'b1);
        issue("div_by_0", 2'b10, F_DIV, 32'd100, 32'd0, 32'hFFFFFFFF, 4'b0100, 1'b1, 1, 1'b0);
`else
        issue("mul_off", 2'b10, F_MUL, 32'h0000FFFF, 32'h00010001, 32'd0, 4'b1111, 1'b1, 1, 1'b1);
        issue("div_off", 2'b10, F_DIV, 32'd100, 32'd7, 32'd0, 4'b1111, 1'b1, 1, 1'b0);
`endif

        // Leave a non-zero result, then abort an in-flight op with reset.
        issue("pre_abort", 2'b10, F_ADD, 32'd3, 32'd4, 32'd7, 4'b0010, 1'b0, 1, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = 2'b10; bus.funct = F_MUL;
        bus.a = 32'h12345; bus.b = 32'h777;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dn = 0;
`ifdef ALU_MULDIV_EN
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.done) dn++;
        end
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if (bus.done) dn++;
        check("abort_no_done", dn, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_result", bus.result, 0);
        check("abort_zero", bus.zero, 1);
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) dn++;
        end
        check("abort_no_late_done", dn, 0);

        issue("post_abort", 2'b10, F_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 4'b1101, 1'b0, 1, 1'b0);

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
